// File: rtl/cam_pkg.sv
// Shared types for the camera pixel capture block: capture FSM states, coordinate widths
// and the RGB565 pixel word.
package cam_pkg;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [2:0] {
    StWaitCfg,
    StWaitVs,
    StSkip,
    StArm,
    StActive
  } cap_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for a slow level signal, with single-cycle rise and fall pulses
// derived from the synchronised copy.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera parallel-bus capture: frame alignment, settling-frame skip, RGB565 byte packing.
// Define CAP_DOWNSCALE_EN to emit a 2x2-decimated image with halved coordinates.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_done_i,
  input  logic           vsync_i,
  input  logic           href_i,
  input  logic [7:0]     d_i,
  output logic           pix_valid_o,
  output rgb565_t        pix_data_o,
  output logic [X_W-1:0] pix_x_o,
  output logic [Y_W-1:0] pix_y_o,
  output logic           frame_start_o,
  output logic           frame_done_o,
  output logic           line_err_o
);

  localparam int unsigned SkipW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [SkipW-1:0] SkipInit = SkipW'(SKIP_FRAMES);
  localparam logic [X_W-1:0]   XLim     = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]   YLim     = Y_W'(V_ACTIVE);

  logic cfg_rise, cfg_fall;

  cam_sync_edge u_cfg_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cfg_done_i),
    .rise_o (cfg_rise),
    .fall_o (cfg_fall)
  );

  logic vs_q, vs_p_q, href_q, href_p_q;
  logic [7:0] d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q     <= 1'b0;
      vs_p_q   <= 1'b0;
      href_q   <= 1'b0;
      href_p_q <= 1'b0;
      d_q      <= 8'h00;
    end else begin
      vs_q     <= vsync_i;
      vs_p_q   <= vs_q;
      href_q   <= href_i;
      href_p_q <= href_q;
      d_q      <= d_i;
    end
  end

  logic vs_rise, vs_fall, href_fall;
  assign vs_rise   = vs_q & ~vs_p_q;
  assign vs_fall   = ~vs_q & vs_p_q;
  assign href_fall = ~href_q & href_p_q;

  cap_state_e       state_q, state_d;
  logic [SkipW-1:0] skip_q, skip_d;
  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic [X_W-1:0]   x_q, x_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0]   y_q, y_d, pix_y_q, pix_y_d;
  rgb565_t          pix_data_q, pix_data_d;
  logic             pix_valid_q, pix_valid_d, fs_q, fs_d, fd_q, fd_d, err_q, err_d;

  // Decimation only gates emission; range checks always see full-resolution x/y.
  logic           keep;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
`ifdef CAP_DOWNSCALE_EN
  assign keep  = ~x_q[0] & ~y_q[0];
  assign out_x = x_q >> 1;
  assign out_y = y_q >> 1;
`else
  assign keep  = 1'b1;
  assign out_x = x_q;
  assign out_y = y_q;
`endif

  logic in_range;
  assign in_range = (x_q < XLim) && (y_q < YLim);

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      StWaitCfg: begin
        skip_d = SkipInit;
        if (cfg_rise) state_d = StWaitVs;
      end
      StWaitVs: begin
        if (vs_rise) state_d = (skip_q != '0) ? StSkip : StArm;
      end
      StSkip: begin
        if (vs_rise) begin
          skip_d = skip_q - 1'b1;
          if (skip_q == SkipW'(1)) state_d = StArm;
        end
      end
      StArm: begin
        phase_d = 1'b0;
        if (vs_fall) begin
          fs_d    = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        if (vs_rise) begin
          fd_d    = 1'b1;
          phase_d = 1'b0;
          state_d = StArm;
        end else if (href_fall) begin
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q != YLim) y_d = y_q + 1'b1;
          if (phase_q) err_d = 1'b1;
        end else if (href_q) begin
          if (!phase_q) begin
            hi_d    = d_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (in_range) begin
              pix_valid_d = keep;
              pix_data_d  = {hi_q, d_q};
              pix_x_d     = out_x;
              pix_y_d     = out_y;
            end else begin
              err_d = 1'b1;
            end
            if (x_q != XLim) x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = StWaitCfg;
    endcase

    if (cfg_fall) begin
      state_d = StWaitCfg;
      skip_d  = SkipInit;
      fs_d    = 1'b0;
      fd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StWaitCfg;
      skip_q      <= SkipInit;
      phase_q     <= 1'b0;
      hi_q        <= 8'h00;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      fs_q        <= 1'b0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      fs_q        <= fs_d;
      fd_q        <= fd_d;
      err_q       <= err_d;
    end
  end

  assign pix_valid_o   = pix_valid_q;
  assign pix_data_o    = pix_data_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign frame_start_o = fs_q;
  assign frame_done_o  = fd_q;
  assign line_err_o    = err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Randomised scoreboard bench for cam_pixel_capture: a frame-level model queues expected
// frame_start / pixel / frame_done events and a monitor compares them as the DUT emits them.
module tb_cam_pixel_capture;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned SK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_done, vsync, href;
  logic [7:0]  d;
  logic        pix_valid, frame_start, frame_done, line_err;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;

  always #5 clk = ~clk;

  cam_pixel_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SKIP_FRAMES (SK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_done_i    (cfg_done),
    .vsync_i       (vsync),
    .href_i        (href),
    .d_i           (d),
    .pix_valid_o   (pix_valid),
    .pix_data_o    (pix_data),
    .pix_x_o       (pix_x),
    .pix_y_o       (pix_y),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .line_err_o    (line_err)
  );

  // kind: 0 pixel, 1 frame_start, 2 frame_done
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] line_b[$];
  int         vectors = 0;
  int         miscompares = 0;

  // Reference model state: capture is decided by counting vsync rises since cfg_done went high.
  bit cfg_on   = 1'b0;
  int rise_cnt = 0;
  bit cap      = 1'b0;
  bit err_exp  = 1'b0;
  int y_m      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (pix_valid || frame_start || frame_done)) begin
      ev_t got, e;
      got.kind = pix_valid ? 2'd0 : (frame_start ? 2'd1 : 2'd2);
      got.data = pix_valid ? pix_data : 16'h0;
      got.x    = pix_valid ? pix_x : 10'h0;
      got.y    = pix_valid ? pix_y : 9'h0;
      vectors++;
      if (32'(pix_valid) + 32'(frame_start) + 32'(frame_done) > 1) begin
        miscompares++;
        $display("FAIL overlap: valid=%b start=%b done=%b expected one at a time",
                 pix_valid, frame_start, frame_done);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got kind=%0d data=%h x=%0d y=%0d expected none",
                 got.kind, got.data, got.x, got.y);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL event: got kind=%0d data=%h x=%0d y=%0d expected kind=%0d data=%h x=%0d y=%0d",
                   got.kind, got.data, got.x, got.y, e.kind, e.data, e.x, e.y);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [15:0] dat, input int x, input int y);
    ev_t e;
    e.kind = k;
    e.data = dat;
    e.x    = 10'(x);
    e.y    = 9'(y);
    exp_q.push_back(e);
  endtask

  // Vsync rise ends the previous frame, vsync fall starts the next one.
  task automatic frame_begin();
    if (cfg_on) begin
      rise_cnt++;
      if (cap) push_ev(2'd2, 16'h0, 0, 0);
      cap = (rise_cnt > int'(SK));
    end else begin
      cap = 1'b0;
    end
    vsync = 1'b1;
    cyc(4);
    vsync = 1'b0;
    if (cap) push_ev(2'd1, 16'h0, 0, 0);
    y_m = 0;
    cyc(3);
  endtask

  task automatic send_line();
    int n;
    n = line_b.size();
    if (cap) begin
      for (int i = 0; i + 1 < n; i += 2) begin
        int px;
        px = i / 2;
        if (px < int'(H) && y_m < int'(V)) begin
`ifdef CAP_DOWNSCALE_EN
          if (px % 2 == 0 && y_m % 2 == 0)
            push_ev(2'd0, {line_b[i], line_b[i+1]}, px / 2, y_m / 2);
`else
          push_ev(2'd0, {line_b[i], line_b[i+1]}, px, y_m);
`endif
        end else begin
          err_exp = 1'b1;
        end
      end
      if (n % 2 == 1) err_exp = 1'b1;
    end
    y_m++;
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      d    = line_b[i];
      cyc(1);
    end
    href = 1'b0;
    d    = 8'($urandom);
    cyc(3);
  endtask

  task automatic good_line();
    line_b.delete();
    repeat (2 * H) line_b.push_back(8'($urandom));
    send_line();
  endtask

  task automatic rand_line();
    int n;
    line_b.delete();
    case ($urandom_range(0, 7))
      0:       n = $urandom_range(1, 2 * H + 3);
      1:       n = 2 * H + 2;
      default: n = 2 * $urandom_range(1, H);
    endcase
    repeat (n) line_b.push_back(8'($urandom));
    send_line();
  endtask

  task automatic set_cfg(input bit v);
    cfg_done = v;
    cfg_on   = v;
    cap      = 1'b0;
    rise_cnt = 0;
    cyc(6);
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_pix_x", 32'(pix_x), 32'd0);
    check("rst_pix_y", 32'(pix_y), 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    cfg_done = 1'b0;
    vsync    = 1'b0;
    href     = 1'b0;
    d        = 8'h00;
    cyc(3);
    check_reset_outputs();
    rst = 1'b1;
    cyc(3);

    // No configuration: frames are ignored entirely.
    repeat (2) begin
      frame_begin();
      repeat (V) rand_line();
    end
    check("no_cfg_err", 32'(line_err), 32'd0);

    set_cfg(1'b1);
    repeat (2) begin
      frame_begin();
      repeat (V) rand_line();
    end
    check("skip_err", 32'(line_err), 32'd0);

    // First captured frame: known RGB565 bytes.
    frame_begin();
    line_b = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line();
    line_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_line();
    good_line();
    check("clean_frame_err", 32'(line_err), 32'(err_exp));

    // Odd byte count drops the partial byte and latches the error.
    frame_begin();
    line_b = '{8'hAA, 8'hBB, 8'hCC};
    send_line();
    line_b = '{8'h01, 8'h02};
    send_line();
    check("odd_line_err", 32'(line_err), 32'(err_exp));

    // Short frame, then a full one.
    frame_begin();
    good_line();
    good_line();
    frame_begin();
    repeat (V) rand_line();

    // Reset part-way through a frame.
    frame_begin();
    good_line();
    check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    cap = 1'b0;
    rise_cnt = 0;
    err_exp = 1'b0;
    exp_q.delete();
    cyc(2);
    check_reset_outputs();
    rst = 1'b1;
    cyc(4);
    good_line();
    repeat (3) begin
      frame_begin();
      repeat (V) good_line();
      check("post_reset_err", 32'(line_err), 32'(err_exp));
    end

    // Randomised frames, including short, overlong and odd lines.
    repeat (20) begin
      frame_begin();
      repeat ($urandom_range(1, V + 1)) rand_line();
      check("rand_frame_err", 32'(line_err), 32'(err_exp));
    end

    // Configuration drop mid-frame: no frame_done, full skip sequence again.
    frame_begin();
    good_line();
    set_cfg(1'b0);
    good_line();
    frame_begin();
    good_line();
    set_cfg(1'b1);
    repeat (4) begin
      frame_begin();
      repeat ($urandom_range(1, V)) rand_line();
      check("recfg_err", 32'(line_err), 32'(err_exp));
    end

    frame_begin();
    cyc(20);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
